// File: rtl/divide_signed_pkg.sv
// Shared types for the iterative signed/unsigned divider (divide_signed).
package divide_signed_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX
  } div_state_e;

  // Width of the step counter that runs W-1..0; at least one bit.
  function automatic int div_cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/divide_signed_if.sv
// stb/ack request bus of the divider: operands in, quotient/remainder out.
interface divide_signed_if #(
  parameter int W = 32
);
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sgn;
  logic         stb;
  logic         ack;
  logic [W-1:0] q;
  logic [W-1:0] r;

  modport master (output a, b, sgn, stb, input ack, q, r);
  modport slave  (input a, b, sgn, stb, output ack, q, r);
endinterface

// File: rtl/divide_signed_step.sv
// One restoring division iteration: shift in a dividend bit, subtract if it fits.
module divide_signed_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] dvd,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_n,
  output logic [W-2:0] dvd_n,
  output logic         qbit
);

  logic [W:0] rem_sh;

  assign rem_sh = {rem, dvd[W-1]};
  assign qbit   = (rem_sh >= {1'b0, dvs});
  // The remainder after a step is always below the divisor, so W bits hold it.
  assign rem_n  = qbit ? W'(rem_sh - {1'b0, dvs}) : rem_sh[W-1:0];
  // Caller appends qbit as the new LSB of the dividend/quotient register.
  assign dvd_n  = dvd[W-2:0];

endmodule

// File: rtl/divide_signed.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIVIDE_FAST_ZERO_EN: divide-by-zero skips RUN and goes straight to FIX.
module divide_signed
  import divide_signed_pkg::*;
#(
  parameter int W = 32
) (
  input  logic            clk,
  input  logic            rst,
  divide_signed_if.slave  bus
);

  localparam int CW = div_cnt_w(W);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic          neg_q_q, neg_q_d;
  logic          neg_r_q, neg_r_d;

  logic          accept;
  logic          b_zero;
  logic [W-1:0]  stp_rem_n;
  logic [W-2:0]  stp_dvd_n;
  logic          stp_qbit;

  // Magnitude of a possibly-signed operand; |INT_MIN| wraps to 2^(W-1) exactly.
  function automatic logic [W-1:0] abs_w(input logic [W-1:0] x, input logic s);
    return (s && x[W-1]) ? -x : x;
  endfunction

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  divide_signed_step #(.W(W)) u_step (
    .rem   (rem_q),
    .dvd   (dvd_q),
    .dvs   (dvs_q),
    .rem_n (stp_rem_n),
    .dvd_n (stp_dvd_n),
    .qbit  (stp_qbit)
  );

  assign accept = bus.stb && (state_q == DIV_IDLE);
  assign b_zero = (bus.b == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          dvd_d   = abs_w(bus.a, bus.sgn);
          dvs_d   = abs_w(bus.b, bus.sgn);
          rem_d   = '0;
          // A zero divisor leaves the all-ones quotient un-negated.
          neg_q_d = bus.sgn & (bus.a[W-1] ^ bus.b[W-1]) & ~b_zero;
          neg_r_d = bus.sgn & bus.a[W-1];
          cnt_d   = CW'(W - 1);
          state_d = DIV_RUN;
`ifdef DIVIDE_FAST_ZERO_EN
          if (b_zero) begin
            dvd_d   = '1;
            rem_d   = abs_w(bus.a, bus.sgn);
            state_d = DIV_FIX;
          end
`endif
        end
      end
      DIV_RUN: begin
        rem_d = stp_rem_n;
        dvd_d = {stp_dvd_n, stp_qbit};
        if (cnt_q == '0) begin
          state_d = DIV_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DIV_FIX: begin
        q_d     = neg_w(dvd_q, neg_q_q);
        r_d     = neg_w(rem_q, neg_r_q);
        ack_d   = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // Control and visible results: reset clears them and aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  // Working datapath: always reloaded on accept, so no reset needed.
  always_ff @(posedge clk) begin
    rem_q   <= rem_d;
    dvd_q   <= dvd_d;
    dvs_q   <= dvs_d;
    neg_q_q <= neg_q_d;
    neg_r_q <= neg_r_d;
  end

  assign bus.ack = ack_q;
  assign bus.q   = q_q;
  assign bus.r   = r_q;

endmodule

// File: tb/tb_divide_signed.sv
// Scoreboard bench for divide_signed: directed operands, expected q/r/latency queued at issue.
module tb_divide_signed;
  localparam int W = 32;
`ifdef DIVIDE_FAST_ZERO_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = W + 2;
`endif
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divide_signed_if #(.W(W)) bus ();
  divide_signed #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
    int           t0;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, req);
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus.ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_ack: got ack=1 q=%h r=%h want no ack", bus.q, bus.r);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_q"}, bus.q, e.q);
        chk({e.name, "_r"}, bus.r, e.r);
        chk_int({e.name, "_lat"}, cyc - e.t0, e.lat);
      end
    end
  end

  task automatic push_exp(input string nm, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input int lat);
    exp_t e;
    e.q = eq; e.r = er; e.lat = lat; e.t0 = cyc; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic issue(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input int lat);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sgn = s; bus.stb = 1'b1;
    push_exp(nm, eq, er, lat);
    @(negedge clk);
    bus.stb = 1'b0;
    // Scramble operands so any late sampling shows up in the result.
    bus.a = ~a; bus.b = ~b; bus.sgn = ~s;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL %s_timeout: got %0d pending want 0", nm, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                     input int lat);
    issue(nm, a, b, s, eq, er, lat);
    wait_idle(nm);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; bus.stb = 1'b0; bus.a = '0; bus.b = '0; bus.sgn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, bus.ack}, '0);
    chk("rst_q", bus.q, '0);
    chk("rst_r", bus.r, '0);
    rst = 1'b0;

    run("pos_div",   32'd100,        32'd7,          1'b1, 32'd14,         32'd2,          LAT);
    run("neg_dvd",   32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE,   LAT);
    run("neg_dvs",   32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,   32'd2,          LAT);
    run("neg_both",  32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   LAT);
    run("ovf",       32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          LAT);
    run("uns_big",   32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   LAT);
    run("dz_uns",    32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd5,          ZLAT);
    run("dz_sgn",    32'd5,          32'd0,          1'b1, 32'hFFFFFFFF,   32'd5,          ZLAT);
    run("dz_neg",    32'hFFFFFFFB,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFB,   ZLAT);
    run("dz_m1",     32'hFFFFFFFF,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   ZLAT);
    run("uns_ones",  32'hFFFFFFFF,   32'd2,          1'b0, 32'h7FFFFFFF,   32'd1,          LAT);
    run("sgn_m1_2",  32'hFFFFFFFF,   32'd2,          1'b1, 32'd0,          32'hFFFFFFFF,   LAT);

    // stb pulsed mid-RUN must be ignored.
    issue("mid_stb", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, LAT);
    repeat (5) @(negedge clk);
    bus.a = 32'd7; bus.b = 32'd2; bus.sgn = 1'b0; bus.stb = 1'b1;
    @(negedge clk);
    bus.stb = 1'b0;
    wait_idle("mid_stb");

    // stb held through ack: a second operation starts in the ack cycle.
    @(negedge clk);
    bus.a = 32'd50; bus.b = 32'd6; bus.sgn = 1'b0; bus.stb = 1'b1;
    push_exp("b2b_a", 32'd8, 32'd2, LAT);
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) seen = 1;
    end
    if (seen == 0) begin
      n_chk++;
      $display("FAIL b2b_wait: got no ack want ack");
    end
    bus.a = 32'hFFFFFFCE; bus.b = 32'd6; bus.sgn = 1'b1;
    push_exp("b2b_b", 32'hFFFFFFF8, 32'hFFFFFFFE, LAT);
    @(negedge clk);
    bus.stb = 1'b0; bus.a = '0; bus.b = '0;
    wait_idle("b2b");

    // Reset in RUN cycle 10 aborts: no ack, outputs cleared.
    issue("abort", 32'd12345, 32'd10, 1'b1, 32'd1234, 32'd5, LAT);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    chk("abort_ack", {31'd0, bus.ack}, '0);
    chk("abort_q", bus.q, '0);
    chk("abort_r", bus.r, '0);
    repeat (40) @(negedge clk);
    run("post_rst",  32'd12345,      32'd10,         1'b1, 32'd1234,       32'd5,          LAT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
